counter_bank: RTL and testbench
===============================

Name: counter_bank

Overview:
- Parametrised multi-channel counter bank; next generation of the single free-running 12-bit simulation counter.
- Adds per-channel enable, direction, load, wrap/saturate mode and a terminal-count pulse.
- Adds a coherent snapshot readout streamed over a valid/ready handshake, so testbench VPI tasks ($clkval-style hooks) can sample every channel from one and the same cycle.

Parameters:
- WIDTH, 12: counter width in bits (≥2).
- NCH, 4: number of channels (≥1).
- CHW, $clog2(NCH) (forced to ≥1): channel-index width; derived, do not override.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  NCH  per-channel count enable.
- dir  in  NCH  per-channel direction; 1 = up, 0 = down.
- sat  in  NCH  per-channel mode; 1 = saturate, 0 = wrap.
- ld  in  NCH  per-channel synchronous load strobe.
- ld_val  in  WIDTH  load value, shared by all channels.
- cnt  out  NCH*WIDTH  live counts; channel i occupies [i*WIDTH +: WIDTH].
- tc  out  NCH  one-cycle terminal-count pulse per channel.
- snap_req  in  1  snapshot request pulse.
- rd_valid  out  1  stream beat valid.
- rd_ready  in  1  stream beat accepted.
- rd_ch  out  CHW  channel index of the current beat.
- rd_data  out  WIDTH  snapshot value of the current beat.
- rd_last  out  1  marks the beat for channel NCH-1.
- busy  out  1  high while a stream is in progress.

Behaviour:
- Reset (async assert, sync-safe deassert): all cnt = 0, tc = 0, rd_valid = 0, rd_ch = 0, rd_data = 0, rd_last = 0, busy = 0, FSM = IDLE.
- Per channel, each rising edge, priority order:
  - ld: cnt <= ld_val; tc = 0 on the next cycle.
  - else en & dir: at all-ones, wrap mode -> 0 and tc = 1; saturate mode -> holds all-ones and tc = 1 on the first cycle it is reached only.
  - else en & ~dir: mirror of the above at 0 (wrap -> all-ones).
  - else: hold.
- tc is registered, high for exactly one cycle, coincident with the cycle cnt shows the wrapped/saturated value.
- Saturate mode: tc does not re-fire while pinned; re-arms once the count leaves the limit.
- Arithmetic: all arithmetic modulo 2^WIDTH, no carry out.
- FSM IDLE:
  - snap_req -> copy every cnt (pre-update value of that edge) into the snapshot registers.
  - rd_ch = 0, rd_valid = 1, busy = 1, go to STREAM.
- FSM STREAM:
  - rd_data = snap[rd_ch]; outputs stay stable while rd_valid & ~rd_ready.
  - On rd_valid & rd_ready: if rd_last -> rd_valid = 0, busy = 0, go to IDLE; else rd_ch++.
  - rd_last = (rd_ch == NCH-1).
  - snap_req while busy is ignored; the snapshot is not retaken.
- Latency: snap_req at edge N -> rd_valid high after edge N; first beat can be accepted at edge N+1; NCH beats minimum.
- Live counting continues unaffected during STREAM.
- Reset mid-stream: aborts immediately, all outputs return to their reset values.
- NCH = 1: a single beat with rd_last = 1.

Optional Feature:
- Macro: COUNTER_BANK_OVF_STICKY_EN.
- Enabled: adds output ovf [NCH] and input ovf_clr [1].
  - ovf[i] sets on any tc[i].
  - ovf_clr clears all bits; a set on the same edge wins over the clear.
  - Reset value 0.
- Disabled: neither port exists; no sticky state.

Decomposition:
- Package counter_bank_pkg:
  - typedef cnt_mode_e {CNT_WRAP, CNT_SAT}.
  - typedef rd_state_e {RD_IDLE, RD_STREAM}.
  - Helper function for the next count value.
- Sub-module counter_cell: one channel (counter + tc logic), instantiated NCH times via generate.
- Top level: snapshot registers, readout FSM, optional sticky logic.

Test Plan:
- Reset then en = 1, dir = 1, sat = 0 on channel 0 for 4096 cycles (WIDTH = 12) -> cnt0 returns to 0; tc0 pulses exactly once, in the cycle cnt0 = 0.
- Channel 1: sat = 1, dir = 0, load 3, count 5 cycles -> values 2, 1, 0, 0, 0; tc1 high only in the first 0 cycle.
- Channel 2: ld and en asserted together with ld_val = 0x0A5 -> cnt2 = 0x0A5 next cycle; no increment that cycle.
- Channels at 10, 20, 30, 40, all counting up; pulse snap_req; hold rd_ready = 0 for 3 cycles, then 1 -> beats (0,10), (1,20), (2,30), (3,40) with rd_last on beat 3; rd_data stable during stall; live counts keep advancing.
- snap_req again during STREAM, then assert rst on beat 2 -> stream aborts, rd_valid = 0, busy = 0, all cnt = 0 immediately.
- COUNTER_BANK_OVF_STICKY_EN defined, force a wrap on channel 3 with ovf_clr asserted on the same edge -> ovf[3] = 1; ovf_clr alone next cycle -> ovf[3] = 0.

Source files
------------

// File: rtl/counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank_pkg
// Description : Shared types and the count-step helper for the counter bank.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package counter_bank_pkg;

    // Per-channel behaviour when a count reaches its limit
    typedef enum logic [0:0] {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Snapshot readout state machine
    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Action a channel takes on the next edge (load is handled separately)
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } cnt_step_e;

    // Wrap needs no special case: modulo arithmetic rolls the count over.
    // Only a saturating channel sitting at its limit refuses to move.
    function automatic cnt_step_e cnt_step(input logic      en,
                                           input logic      dir,
                                           input logic      at_limit,
                                           input cnt_mode_e mode);
        cnt_step_e step;
        step = STEP_HOLD;
        if (en && !(at_limit && (mode == CNT_SAT))) begin
            step = dir ? STEP_UP : STEP_DOWN;
        end
        return step;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_cell.sv
`default_nettype none
// ============================================================================
// Module      : counter_cell
// Description : One counter channel: load / up / down, wrap or saturate, and
//               a registered one-cycle terminal-count pulse.
//               COUNTER_BANK_OVF_STICKY_EN exposes tc_set, the pulse's
//               next-state value, for the sticky overflow flags.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module counter_cell
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  cnt_mode_e        mode,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
`ifdef COUNTER_BANK_OVF_STICKY_EN
    output logic             tc_set,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;

    logic [WIDTH-1:0] w_limit;
    logic [WIDTH-1:0] w_next;
    logic             w_at_limit;
    logic             w_tc_d;
    cnt_step_e        w_step;

    // Next count and terminal-count decision for this edge
    always_comb begin
        w_limit    = dir ? C_ALL_ONES : '0;
        w_at_limit = (cnt == w_limit);
        w_step     = cnt_step(en, dir, w_at_limit, mode);
        case (w_step)
            STEP_UP:   w_next = cnt + WIDTH'(1);
            STEP_DOWN: w_next = cnt - WIDTH'(1);
            default:   w_next = cnt;
        endcase
        if (ld) begin
            w_next = ld_val;
            w_tc_d = 1'b0;
        end else if (mode == CNT_WRAP) begin
            // Pulse on the roll-over edge
            w_tc_d = en && w_at_limit;
        end else begin
            // Pulse only on arrival at the limit, never while pinned there
            w_tc_d = en && !w_at_limit && (w_next == w_limit);
        end
    end

    // Count and terminal-count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else begin
            cnt <= w_next;
            tc  <= w_tc_d;
        end
    end

`ifdef COUNTER_BANK_OVF_STICKY_EN
    assign tc_set = w_tc_d;
`endif

endmodule
`default_nettype wire

// File: rtl/counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank
// Description : NCH-channel counter bank with a coherent snapshot of every
//               channel streamed out over a valid/ready handshake.
//               Optional COUNTER_BANK_OVF_STICKY_EN adds sticky per-channel
//               overflow flags (ovf) with a global clear (ovf_clr).
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int NCH   = 4,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       dir,
    input  logic [NCH-1:0]       sat,
    input  logic [NCH-1:0]       ld,
    input  logic [WIDTH-1:0]     ld_val,
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       tc,
    input  logic                 snap_req,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [CHW-1:0]       rd_ch,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_last,
`ifdef COUNTER_BANK_OVF_STICKY_EN
    output logic [NCH-1:0]       ovf,
    input  logic                 ovf_clr,
`endif
    output logic                 busy
);

    localparam logic [CHW-1:0] C_LAST_CH = CHW'(NCH - 1);

`ifdef COUNTER_BANK_OVF_STICKY_EN
    logic [NCH-1:0] w_tc_set;
    logic [NCH-1:0] r_ovf;
`endif

    rd_state_e        r_state;
    logic [WIDTH-1:0] r_snap [NCH];
    logic [CHW-1:0]   w_next_ch;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        counter_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .en     (en[gi]),
            .dir    (dir[gi]),
            .mode   (sat[gi] ? CNT_SAT : CNT_WRAP),
            .ld     (ld[gi]),
            .ld_val (ld_val),
`ifdef COUNTER_BANK_OVF_STICKY_EN
            .tc_set (w_tc_set[gi]),
`endif
            .cnt    (cnt[gi*WIDTH +: WIDTH]),
            .tc     (tc[gi])
        );
    end

    assign w_next_ch = rd_ch + CHW'(1);

    // Snapshot capture and beat-by-beat readout; the first beat is taken
    // straight from the live count so it is valid the cycle after the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RD_IDLE;
            rd_valid <= 1'b0;
            rd_ch    <= '0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (snap_req) begin
                        for (int i = 0; i < NCH; i++) begin
                            r_snap[i] <= cnt[i*WIDTH +: WIDTH];
                        end
                        rd_ch    <= '0;
                        rd_data  <= cnt[WIDTH-1:0];
                        rd_last  <= (C_LAST_CH == '0);
                        rd_valid <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    // rd_valid is always high here; snap_req is ignored
                    if (rd_ready) begin
                        if (rd_last) begin
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            busy     <= 1'b0;
                            r_state  <= RD_IDLE;
                        end else begin
                            rd_ch   <= w_next_ch;
                            rd_data <= r_snap[w_next_ch];
                            rd_last <= (w_next_ch == C_LAST_CH);
                        end
                    end
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

`ifdef COUNTER_BANK_OVF_STICKY_EN
    // Sticky overflow: a new terminal count beats a clear on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= w_tc_set | (r_ovf & ~{NCH{ovf_clr}});
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_bank
// Description : Self-checking bench for counter_bank (WIDTH=12, NCH=4).
//               Directed scenarios plus a randomized run compared against an
//               arithmetic reference model of counts, pulses and the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_bank;

    localparam int WIDTH = 12;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       en, dir, sat, ld;
    logic [WIDTH-1:0]     ld_val;
    logic [NCH*WIDTH-1:0] cnt;
    logic [NCH-1:0]       tc;
    logic                 snap_req, rd_valid, rd_ready, rd_last, busy;
    logic [CHW-1:0]       rd_ch;
    logic [WIDTH-1:0]     rd_data;
`ifdef COUNTER_BANK_OVF_STICKY_EN
    logic [NCH-1:0]       ovf;
    logic                 ovf_clr;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt  [NCH];
    bit m_tc   [NCH];
    bit m_ovf  [NCH];
    int m_snap [NCH];
    bit m_busy;
    int m_idx;

    counter_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .sat      (sat),
        .ld       (ld),
        .ld_val   (ld_val),
        .cnt      (cnt),
        .tc       (tc),
        .snap_req (snap_req),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_ch    (rd_ch),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
`ifdef COUNTER_BANK_OVF_STICKY_EN
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int chv(input int c);
        return int'(cnt[c*WIDTH +: WIDTH]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_tc[c] = 0; m_ovf[c] = 0; m_snap[c] = 0;
        end
        m_busy = 0;
        m_idx  = 0;
    endtask

    // Advance the model by one edge using the inputs currently applied,
    // then step the DUT across that edge and settle 1ns past it.
    task automatic tick();
        int n_cnt [NCH];
        bit n_tc  [NCH];
        int v;
        int lim;
        for (int c = 0; c < NCH; c++) begin
            v   = m_cnt[c];
            lim = dir[c] ? MAXV : 0;
            n_cnt[c] = v;
            n_tc[c]  = 0;
            if (ld[c]) begin
                n_cnt[c] = int'(ld_val);
            end else if (en[c]) begin
                if (v == lim) begin
                    if (!sat[c]) begin
                        n_cnt[c] = dir[c] ? 0 : MAXV;
                        n_tc[c]  = 1;
                    end
                end else begin
                    n_cnt[c] = dir[c] ? v + 1 : v - 1;
                    n_tc[c]  = sat[c] && (n_cnt[c] == lim);
                end
            end
        end
        if (!m_busy) begin
            if (snap_req) begin
                for (int c = 0; c < NCH; c++) m_snap[c] = m_cnt[c];
                m_busy = 1;
                m_idx  = 0;
            end
        end else if (rd_ready) begin
            if (m_idx == NCH - 1) m_busy = 0;
            else m_idx++;
        end
`ifdef COUNTER_BANK_OVF_STICKY_EN
        for (int c = 0; c < NCH; c++) m_ovf[c] = n_tc[c] | (m_ovf[c] & !ovf_clr);
`endif
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = n_cnt[c];
            m_tc[c]  = n_tc[c];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = '0; dir = '0; sat = '0; ld = '0; ld_val = '0;
        snap_req = 1'b0; rd_ready = 1'b0;
`ifdef COUNTER_BANK_OVF_STICKY_EN
        ovf_clr = 1'b0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0h expected 0", cnt); end
        checks++; if (tc !== '0) begin errors++; $display("FAIL reset_tc: got %0b expected 0", tc); end
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_hs: rd_valid=%0b busy=%0b expected 0 0", rd_valid, busy); end
        checks++; if (rd_ch !== '0 || rd_data !== '0 || rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd: ch=%0d data=%0h last=%0b expected 0 0 0", rd_ch, rd_data, rd_last); end
`ifdef COUNTER_BANK_OVF_STICKY_EN
        checks++; if (ovf !== '0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
`endif
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_wrap();
        int pulses = 0;
        en = 4'b0001; dir = 4'b0001; sat = '0; ld = '0;
        for (int k = 0; k < 4096; k++) begin
            tick();
            if (tc[0]) pulses++;
            checks++; if (chv(0) !== m_cnt[0] || tc[0] !== m_tc[0]) begin errors++; $display("FAIL wrap_step%0d: cnt=%0d tc=%0b expected %0d %0b", k, chv(0), tc[0], m_cnt[0], m_tc[0]); end
        end
        checks++; if (chv(0) !== 0) begin errors++; $display("FAIL wrap_final: cnt0=%0d expected 0", chv(0)); end
        checks++; if (pulses !== 1 || tc[0] !== 1'b1) begin errors++; $display("FAIL wrap_tc: pulses=%0d tc_at_zero=%0b expected 1 1", pulses, tc[0]); end
        checks++; if (cnt[NCH*WIDTH-1:WIDTH] !== '0) begin errors++; $display("FAIL wrap_idle_ch: got %0h expected 0", cnt[NCH*WIDTH-1:WIDTH]); end
    endtask

    task automatic test_sat();
        int exp_v [5] = '{2, 1, 0, 0, 0};
        bit exp_t [5] = '{0, 0, 1, 0, 0};
        en = '0; dir = '0; sat = 4'b0010; ld = 4'b0010; ld_val = 12'd3;
        tick();
        checks++; if (chv(1) !== 3) begin errors++; $display("FAIL sat_load: cnt1=%0d expected 3", chv(1)); end
        ld = '0; en = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (chv(1) !== exp_v[k] || tc[1] !== exp_t[k]) begin errors++; $display("FAIL sat_step%0d: cnt1=%0d tc1=%0b expected %0d %0b", k, chv(1), tc[1], exp_v[k], exp_t[k]); end
        end
    endtask

    task automatic test_load_priority();
        en = 4'b0100; dir = 4'b0100; sat = '0; ld = 4'b0100; ld_val = 12'h0A5;
        tick();
        checks++; if (chv(2) !== 'h0A5 || tc[2] !== 1'b0) begin errors++; $display("FAIL ld_prio: cnt2=%0h tc2=%0b expected a5 0", chv(2), tc[2]); end
        ld = '0;
        tick();
        checks++; if (chv(2) !== 'h0A6) begin errors++; $display("FAIL ld_then_count: cnt2=%0h expected a6", chv(2)); end
    endtask

    task automatic test_snapshot();
        en = '0; sat = '0; dir = '1;
        for (int c = 0; c < NCH; c++) begin
            ld = NCH'(1 << c);
            ld_val = WIDTH'(10 * (c + 1));
            tick();
        end
        ld = '0; en = '1; snap_req = 1'b1; rd_ready = 1'b0;
        tick();
        snap_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (rd_valid !== 1'b1 || busy !== 1'b1 || rd_ch !== 2'd0 || rd_data !== 12'd10) begin errors++; $display("FAIL snap_stall%0d: valid=%0b busy=%0b ch=%0d data=%0d expected 1 1 0 10", k, rd_valid, busy, rd_ch, rd_data); end
            checks++; if (chv(0) !== 11 + k) begin errors++; $display("FAIL snap_live%0d: cnt0=%0d expected %0d", k, chv(0), 11 + k); end
            tick();
        end
        rd_ready = 1'b1;
        for (int b = 0; b < NCH; b++) begin
            checks++; if (rd_valid !== 1'b1 || int'(rd_ch) !== b || int'(rd_data) !== 10 * (b + 1) || rd_last !== (b == NCH - 1)) begin errors++; $display("FAIL snap_beat%0d: valid=%0b ch=%0d data=%0d last=%0b expected 1 %0d %0d %0b", b, rd_valid, rd_ch, rd_data, rd_last, b, 10 * (b + 1), b == NCH - 1); end
            tick();
        end
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL snap_done: valid=%0b busy=%0b expected 0 0", rd_valid, busy); end
        checks++; if (chv(3) !== m_cnt[3]) begin errors++; $display("FAIL snap_live_end: cnt3=%0d expected %0d", chv(3), m_cnt[3]); end
        rd_ready = 1'b0;
    endtask

    task automatic test_abort();
        snap_req = 1'b1; rd_ready = 1'b0;
        tick();
        snap_req = 1'b0; rd_ready = 1'b1;
        checks++; if (rd_ch !== 2'd0 || int'(rd_data) !== m_snap[0]) begin errors++; $display("FAIL abort_beat0: ch=%0d data=%0d expected 0 %0d", rd_ch, rd_data, m_snap[0]); end
        tick();
        snap_req = 1'b1;
        checks++; if (rd_ch !== 2'd1 || int'(rd_data) !== m_snap[1] || busy !== 1'b1) begin errors++; $display("FAIL abort_beat1: ch=%0d data=%0d busy=%0b expected 1 %0d 1", rd_ch, rd_data, busy, m_snap[1]); end
        tick();
        snap_req = 1'b0;
        checks++; if (rd_ch !== 2'd2 || int'(rd_data) !== m_snap[2]) begin errors++; $display("FAIL abort_ignore_req: ch=%0d data=%0d expected 2 %0d", rd_ch, rd_data, m_snap[2]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0) begin errors++; $display("FAIL abort_hs: valid=%0b busy=%0b last=%0b expected 0 0 0", rd_valid, busy, rd_last); end
        checks++; if (cnt !== '0 || tc !== '0) begin errors++; $display("FAIL abort_cnt: cnt=%0h tc=%0b expected 0 0", cnt, tc); end
        @(posedge clk); #1;
        rst = 1'b0;
        en = '0; rd_ready = 1'b0;
        model_reset();
    endtask

`ifdef COUNTER_BANK_OVF_STICKY_EN
    task automatic test_ovf();
        en = '0; sat = '0; dir = 4'b1000; ld = 4'b1000; ld_val = WIDTH'(MAXV); ovf_clr = 1'b1;
        tick();
        checks++; if (ovf !== '0) begin errors++; $display("FAIL ovf_clear0: got %0b expected 0", ovf); end
        ld = '0; en = 4'b1000; ovf_clr = 1'b1;
        tick();
        checks++; if (chv(3) !== 0 || tc[3] !== 1'b1 || ovf[3] !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: cnt3=%0d tc3=%0b ovf3=%0b expected 0 1 1", chv(3), tc[3], ovf[3]); end
        en = '0; ovf_clr = 1'b1;
        tick();
        checks++; if (ovf[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear: ovf3=%0b expected 0", ovf[3]); end
        ovf_clr = 1'b0;
    endtask
`endif

    task automatic test_random();
        int pick;
        for (int k = 0; k < 3000; k++) begin
            en  = NCH'($urandom);
            dir = NCH'($urandom);
            sat = NCH'($urandom);
            ld  = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
            pick = int'($urandom_range(0, 4));
            case (pick)
                0: ld_val = '0;
                1: ld_val = 12'd1;
                2: ld_val = WIDTH'(MAXV);
                3: ld_val = WIDTH'(MAXV - 1);
                default: ld_val = WIDTH'($urandom);
            endcase
            snap_req = ($urandom_range(0, 9) == 0);
            rd_ready = 1'($urandom);
`ifdef COUNTER_BANK_OVF_STICKY_EN
            ovf_clr = ($urandom_range(0, 7) == 0);
`endif
            tick();
            for (int c = 0; c < NCH; c++) begin
                checks++; if (chv(c) !== m_cnt[c] || tc[c] !== m_tc[c]) begin errors++; $display("FAIL rnd%0d_ch%0d: cnt=%0d tc=%0b expected %0d %0b", k, c, chv(c), tc[c], m_cnt[c], m_tc[c]); end
`ifdef COUNTER_BANK_OVF_STICKY_EN
                checks++; if (ovf[c] !== m_ovf[c]) begin errors++; $display("FAIL rnd%0d_ovf%0d: got %0b expected %0b", k, c, ovf[c], m_ovf[c]); end
`endif
            end
            checks++; if (rd_valid !== m_busy || busy !== m_busy) begin errors++; $display("FAIL rnd%0d_hs: valid=%0b busy=%0b expected %0b", k, rd_valid, busy, m_busy); end
            if (m_busy) begin
                checks++; if (int'(rd_ch) !== m_idx || int'(rd_data) !== m_snap[m_idx] || rd_last !== (m_idx == NCH - 1)) begin errors++; $display("FAIL rnd%0d_beat: ch=%0d data=%0d last=%0b expected %0d %0d %0b", k, rd_ch, rd_data, rd_last, m_idx, m_snap[m_idx], m_idx == NCH - 1); end
            end
        end
        snap_req = 1'b0; rd_ready = 1'b0; en = '0; ld = '0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_sat();
        test_load_priority();
        test_snapshot();
        test_abort();
`ifdef COUNTER_BANK_OVF_STICKY_EN
        test_ovf();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
